vic_responder: RTL and testbench



---
 rtl/vic_responder_pkg.sv | 37 +++
 rtl/vic_responder_prio_enc.sv | 33 +++
 rtl/vic_responder.sv | 131 +++++++++++++
 tb/tb_vic_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vic_responder_pkg.sv
// -----------------------------------------------------------------------------
// vic_responder_pkg
// Shared definitions for the vectored-interrupt responder: handshake state
// encoding, vector width, the default DVK peripheral vector map and a helper
// that sizes source-index buses.
// -----------------------------------------------------------------------------
package vic_responder_pkg;

    localparam int VEC_W = 16;

    // The CPU fetches a PS/PC pair from the vector, so a vector is always
    // longword aligned; bits [1:0] of a granted vector are cleared.
    localparam logic [VEC_W-1:0] VEC_ALIGN_MASK = 16'hFFFC;

    // Standard DVK peripheral vectors, in priority order (source 0 first).
    localparam logic [VEC_W-1:0] DVK_VEC_TTY_TX  = 16'o000064;
    localparam logic [VEC_W-1:0] DVK_VEC_TTY_RX  = 16'o000060;
    localparam logic [VEC_W-1:0] DVK_VEC_PTR     = 16'o000070;
    localparam logic [VEC_W-1:0] DVK_VEC_DISK    = 16'o000310;
    localparam logic [VEC_W-1:0] DVK_DEFAULT_VEC = 16'o000000;

    // Source k lives in bits [16k+15:16k].
    localparam logic [4*VEC_W-1:0] DVK_VECTORS =
        {DVK_VEC_DISK, DVK_VEC_PTR, DVK_VEC_TTY_RX, DVK_VEC_TTY_TX};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // virq follows the registered pending set
        ST_HOLD = 2'd1,   // vector and iack held until the CPU drops istb
        ST_GAP  = 2'd2    // one quiet cycle so the acked source can drop its request
    } state_t;

    // Width of an index into n sources; never zero so a 1-source build works.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vic_responder_prio_enc.sv
// -----------------------------------------------------------------------------
// vic_responder_prio_enc
// Fixed-priority encoder: index 0 has the highest priority.
// Ports:
//   req_i    in  N      request vector
//   valid_o  out 1      at least one request set
//   idx_o    out IDX_W  index of the lowest set request (0 when none)
// -----------------------------------------------------------------------------
module vic_responder_prio_enc
    import vic_responder_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // NOTE: every output of an always_comb gets a value before any branch,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Scan from the top down so the lowest set index is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/vic_responder.sv
// -----------------------------------------------------------------------------
// vic_responder
// Peripheral-side end of the vectored interrupt handshake. Collects level
// requests, raises virq, answers the CPU vector strobe with the winning
// source's vector and pulses irq_ack to that source for one cycle.
// Ports:
//   wb_clk_i  in  1     clock, rising edge
//   wb_rst_i  in  1     synchronous reset, active high
//   irq_req   in  NSRC  level requests, held until irq_ack
//   irq_mask  in  NSRC  1 = source disabled
//   irq_ack   out NSRC  one-cycle grant pulse to the winning source
//   virq      out 1     interrupt request to the CPU
//   istb      in  1     vector strobe from the CPU, held until iack
//   ivec      out 16    vector bus to the CPU
//   iack      out 1     vector valid
// -----------------------------------------------------------------------------
module vic_responder
    import vic_responder_pkg::*;
#(
    parameter int                        NSRC        = 4,
    parameter logic [NSRC*VEC_W-1:0]     VECTORS     = (NSRC*VEC_W)'(DVK_VECTORS),
    parameter logic [VEC_W-1:0]          DEFAULT_VEC = DVK_DEFAULT_VEC
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [NSRC-1:0]   irq_req,
    input  logic [NSRC-1:0]   irq_mask,
    output logic [NSRC-1:0]   irq_ack,
    output logic              virq,
    input  logic              istb,
    output logic [VEC_W-1:0]  ivec,
    output logic              iack
);

    localparam int IDX_W = idx_width(NSRC);

    state_t              state_q, state_d;
    logic [NSRC-1:0]     pend_q, pend_d;
    logic                virq_q, virq_d;
    logic [VEC_W-1:0]    ivec_q, ivec_d;
    logic                iack_q, iack_d;
    logic [NSRC-1:0]     irq_ack_q, irq_ack_d;

    logic                win_valid;
    logic [IDX_W-1:0]    win_idx;
    logic [VEC_W-1:0]    win_vec;

    // Arbitration works on the registered pending set, so a request that
    // rises on the strobe sampling edge is not eligible for that grant.
    assign pend_d = irq_req & ~irq_mask;

    vic_responder_prio_enc #(
        .N     (NSRC),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req_i   (pend_q),
        .valid_o (win_valid),
        .idx_o   (win_idx)
    );

    always_comb begin
        win_vec = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (win_idx == IDX_W'(k)) begin
                win_vec = VECTORS[k*VEC_W +: VEC_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ivec_d    = ivec_q;
        iack_d    = iack_q;
        irq_ack_d = '0;   // grant is a single-cycle pulse
        case (state_q)
            ST_IDLE: begin
                // A strobe already high on entry is treated as a new one.
                if (istb) begin
                    state_d = ST_HOLD;
                    iack_d  = 1'b1;
                    if (win_valid) begin
                        ivec_d    = win_vec & VEC_ALIGN_MASK;
                        irq_ack_d = NSRC'(1) << win_idx;
                    end else begin
                        // Source withdrew before the strobe: still answer.
                        ivec_d = DEFAULT_VEC;
                    end
                end
            end
            ST_HOLD: begin
                if (!istb) begin
                    state_d = ST_GAP;
                    iack_d  = 1'b0;
                    ivec_d  = '0;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // virq is a true register: it shows |pend only while the FSM will sit
    // in IDLE, which also keeps it low through HOLD and GAP.
    assign virq_d = (state_d == ST_IDLE) && (|pend_d);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            pend_q    <= '0;
            virq_q    <= 1'b0;
            ivec_q    <= '0;
            iack_q    <= 1'b0;
            irq_ack_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            virq_q    <= virq_d;
            ivec_q    <= ivec_d;
            iack_q    <= iack_d;
            irq_ack_q <= irq_ack_d;
        end
    end

    assign virq    = virq_q;
    assign ivec    = ivec_q;
    assign iack    = iack_q;
    assign irq_ack = irq_ack_q;

endmodule

// File: tb/tb_vic_responder.sv
// -----------------------------------------------------------------------------
// tb_vic_responder
// Self-checking bench for vic_responder: directed handshake scenarios followed
// by randomized peripheral/CPU activity, all compared every cycle against a
// transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_vic_responder;

    logic        clk;
    logic        rst;
    logic [3:0]  irq_req;
    logic [3:0]  irq_mask;
    logic [3:0]  irq_ack;
    logic        virq;
    logic        istb;
    logic [15:0] ivec;
    logic        iack;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    vic_responder dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .irq_req  (irq_req),
        .irq_mask (irq_mask),
        .irq_ack  (irq_ack),
        .virq     (virq),
        .istb     (istb),
        .ivec     (ivec),
        .iack     (iack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] vec_tab [4] = '{16'o000064, 16'o000060, 16'o000070, 16'o000310};
    localparam logic [15:0] DEF_VEC = 16'o000000;

    logic        m_busy;      // vector delivered, waiting for istb to fall
    logic        m_gap;       // quiet cycle after a completed handshake
    logic [3:0]  m_pend;      // requests seen at the previous edge
    logic        m_virq;
    logic        m_iack;
    logic [15:0] m_vec;
    logic [3:0]  m_ack;

    function automatic int lowest_src(input logic [3:0] p);
        for (int i = 0; i < 4; i++) begin
            if (p[i]) return i;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_edge();
        int w;
        if (rst) begin
            m_busy = 1'b0; m_gap = 1'b0; m_pend = '0;
            m_virq = 1'b0; m_iack = 1'b0; m_vec = '0; m_ack = '0;
        end else begin
            m_ack = '0;
            if (m_busy) begin
                if (!istb) begin
                    m_busy = 1'b0; m_gap = 1'b1; m_iack = 1'b0; m_vec = '0;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (istb) begin
                m_busy = 1'b1;
                m_iack = 1'b1;
                w = lowest_src(m_pend);
                if (w >= 0) begin
                    m_vec = vec_tab[w] & 16'hFFFC;
                    m_ack = 4'(1 << w);
                end else begin
                    m_vec = DEF_VEC;
                end
            end
            m_pend = irq_req & ~irq_mask;
            m_virq = !m_busy && !m_gap && (m_pend != 0);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0o want=%0o", tag, cycle, got, exp);
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cycle++;
        check("virq",    32'(virq),    32'(m_virq));
        check("iack",    32'(iack),    32'(m_iack));
        check("ivec",    32'(ivec),    32'(m_vec));
        check("irq_ack", 32'(irq_ack), 32'(m_ack));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; irq_req = 4'b1111; irq_mask = '0; istb = 1'b0;
        m_busy = 1'b0; m_gap = 1'b0; m_pend = '0;
        m_virq = 1'b0; m_iack = 1'b0; m_vec = '0; m_ack = '0;

        // Reset with every source requesting.
        steps(2);
        check("rst_virq", 32'(virq), 32'd0);
        check("rst_iack", 32'(iack), 32'd0);
        check("rst_ivec", 32'(ivec), 32'd0);
        rst = 1'b0;
        steps(2);
        check("rel_virq", 32'(virq), 32'd1);
        irq_req = '0;
        steps(2);

        // Single source 2.
        irq_req = 4'b0100;
        step();
        istb = 1'b1;
        step();
        check("s2_ivec", 32'(ivec),    32'o70);
        check("s2_iack", 32'(iack),    32'd1);
        check("s2_ack",  32'(irq_ack), 32'b0100);
        check("s2_virq", 32'(virq),    32'd0);
        irq_req = '0;
        step();
        check("s2_ack1", 32'(irq_ack), 32'd0);
        istb = 1'b0;
        step();
        check("s2_iackf", 32'(iack), 32'd0);
        check("s2_gapv",  32'(virq), 32'd0);
        step();

        // Priority: 1 beats 3, then 3 is served after GAP.
        irq_req = 4'b1010;
        step();
        istb = 1'b1;
        step();
        check("pr_ivec1", 32'(ivec),    32'o60);
        check("pr_ack1",  32'(irq_ack), 32'b0010);
        irq_req = 4'b1000;
        step();
        istb = 1'b0;
        step();
        check("pr_gapv", 32'(virq), 32'd0);
        step();
        check("pr_virq", 32'(virq), 32'd1);
        istb = 1'b1;
        step();
        check("pr_ivec3", 32'(ivec),    32'o310);
        check("pr_ack3",  32'(irq_ack), 32'b1000);
        irq_req = '0; istb = 1'b0;
        steps(3);

        // Masking.
        irq_req = 4'b0001; irq_mask = 4'b0001;
        steps(2);
        check("mask_virq", 32'(virq), 32'd0);
        irq_mask = '0;
        step();
        check("unmask_virq", 32'(virq), 32'd1);

        // Withdrawn request answers with the default vector.
        irq_req = '0;
        step();
        istb = 1'b1;
        step();
        check("wd_ivec", 32'(ivec),    32'(DEF_VEC));
        check("wd_iack", 32'(iack),    32'd1);
        check("wd_ack",  32'(irq_ack), 32'd0);
        istb = 1'b0;
        steps(2);

        // Reset in the middle of a handshake.
        irq_req = 4'b0001;
        step();
        istb = 1'b1;
        step();
        irq_req = '0;
        rst = 1'b1;
        step();
        check("mr_iack", 32'(iack),    32'd0);
        check("mr_ivec", 32'(ivec),    32'd0);
        check("mr_ack",  32'(irq_ack), 32'd0);
        rst = 1'b0; istb = 1'b0;
        irq_req = 4'b0010;
        step();
        istb = 1'b1;
        step();
        check("mr_idle_ivec", 32'(ivec), 32'o60);
        irq_req = '0; istb = 1'b0;
        steps(3);

        // Randomized traffic: peripherals drop requests when acked, the CPU
        // strobes on virq (occasionally without it) and releases after iack.
        for (int n = 0; n < 3000; n++) begin
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom % 400 == 0) begin
                rst = 1'b1;
            end
            for (int k = 0; k < 4; k++) begin
                if (m_ack[k]) irq_req[k] = 1'b0;
                else if (!irq_req[k] && ($urandom % 8 == 0)) irq_req[k] = 1'b1;
                else if (irq_req[k] && ($urandom % 64 == 0)) irq_req[k] = 1'b0;
            end
            if ($urandom % 40 == 0) irq_mask = 4'($urandom & $urandom);
            if (!istb) begin
                if ((m_virq && ($urandom % 3 == 0)) || ($urandom % 60 == 0)) istb = 1'b1;
            end else if (m_iack && ($urandom % 2 == 0)) begin
                istb = 1'b0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
